// File: rtl/ucsbece154_icache.sv
// Direct-mapped read-only instruction cache with critical-word-first miss forwarding.
// Hits and the critical-word forward are combinational; memory requests are registered.
module ucsbece154_icache #(
  parameter int unsigned NUM_SETS    = 8,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReadEnable,
  input  logic [31:0] ReadAddress,
  output logic [31:0] Instruction,
  output logic        Ready,
  output logic        MemReadRequest,
  output logic [31:0] MemReadAddress,
  input  logic [31:0] MemDataIn,
  input  logic        MemDataReady
);

  localparam int unsigned OFF_W = $clog2(BLOCK_WORDS);
  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = 32 - 2 - OFF_W - IDX_W;
  localparam int unsigned CNT_W = $clog2(BLOCK_WORDS + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_CRIT, FILL} state_t;

  state_t            state;
  logic [31:0]       data_q  [NUM_SETS][BLOCK_WORDS];
  logic [TAG_W-1:0]  tag_q   [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [CNT_W-1:0]  beat_q;

  logic [OFF_W-1:0]  rd_off;
  logic [IDX_W-1:0]  rd_idx;
  logic [TAG_W-1:0]  rd_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              last_beat;

  // The latched miss address doubles as the fill index/tag holder.
  assign rd_off    = ReadAddress[2 +: OFF_W];
  assign rd_idx    = ReadAddress[2 + OFF_W +: IDX_W];
  assign rd_tag    = ReadAddress[31 -: TAG_W];
  assign fill_idx  = MemReadAddress[2 + OFF_W +: IDX_W];
  assign fill_tag  = MemReadAddress[31 -: TAG_W];
  assign hit       = ReadEnable && valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign last_beat = (beat_q == CNT_W'(BLOCK_WORDS));

  // Fetch response: hit from IDLE or the critical word straight off the bus.
  always_comb begin
    Ready       = 1'b0;
    Instruction = '0;
    case (state)
      IDLE: begin
        if (hit) begin
          Ready       = 1'b1;
          Instruction = data_q[rd_idx][rd_off];
        end
      end
      WAIT_CRIT: begin
        if (MemDataReady) begin
          Ready       = 1'b1;
          Instruction = MemDataIn;
        end
      end
      default: ;
    endcase
  end

  // Control FSM, valid bits and memory request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      valid_q        <= '0;
      MemReadRequest <= 1'b0;
      MemReadAddress <= '0;
      beat_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ReadEnable && !hit) begin
            MemReadAddress <= ReadAddress;
            MemReadRequest <= 1'b1;
            state          <= REQ;
          end
        end
        REQ: begin
          MemReadRequest    <= 1'b0;
          valid_q[fill_idx] <= 1'b0;
          state             <= WAIT_CRIT;
        end
        WAIT_CRIT: begin
          if (MemDataReady) begin
            beat_q <= CNT_W'(1);
            state  <= FILL;
          end
        end
        FILL: begin
          if (MemDataReady) begin
            if (last_beat) begin
              valid_q[fill_idx] <= 1'b1;
              beat_q            <= '0;
              state             <= IDLE;
            end else begin
              beat_q <= beat_q + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage; beats 1..BLOCK_WORDS land in order, tag written with the last one.
  always_ff @(posedge clk) begin
    if (state == FILL && MemDataReady) begin
      data_q[fill_idx][OFF_W'(beat_q - CNT_W'(1))] <= MemDataIn;
      if (last_beat) begin
        tag_q[fill_idx] <= fill_tag;
      end
    end
  end

endmodule

// File: tb/tb_ucsbece154_icache.sv
// Self-checking bench for ucsbece154_icache: burst memory model plus a line-residency
// reference model; directed scenarios followed by randomized reads.
module tb_ucsbece154_icache;

  localparam int unsigned BW   = 4;
  localparam int unsigned SETS = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ReadEnable = 1'b0;
  logic [31:0] ReadAddress = '0;
  logic [31:0] Instruction;
  logic        Ready;
  logic        MemReadRequest;
  logic [31:0] MemReadAddress;
  logic [31:0] MemDataIn = '0;
  logic        MemDataReady = 1'b0;

  always #5 clk = ~clk;

  ucsbece154_icache #(.NUM_SETS(SETS), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .reset(reset), .ReadEnable(ReadEnable), .ReadAddress(ReadAddress),
    .Instruction(Instruction), .Ready(Ready), .MemReadRequest(MemReadRequest),
    .MemReadAddress(MemReadAddress), .MemDataIn(MemDataIn), .MemDataReady(MemDataReady)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Program image: word k of the text segment at 0x00010000 holds 0x1000+k.
  function automatic logic [31:0] text(input logic [31:0] a);
    return 32'h1000 + ((a - 32'h0001_0000) >> 2);
  endfunction

  // Request monitor.
  int          req_count = 0;
  int          last_req_cyc = 0;
  logic [31:0] last_req_addr = '0;
  always @(negedge clk) begin
    if (MemReadRequest) begin
      req_count++;
      last_req_cyc  = cyc;
      last_req_addr = MemReadAddress;
    end
  end

  // Burst memory: T0 delay, critical word, then the whole line in order.
  int          t0_delay = 40;
  bit          busy = 1'b0;
  int          delay = 0;
  int          beat = 0;
  logic [31:0] crit_addr = '0;
  always @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0; MemDataReady <= 1'b0; MemDataIn <= '0; beat <= 0; delay <= 0;
    end else if (!busy) begin
      MemDataReady <= 1'b0;
      if (MemReadRequest) begin
        busy <= 1'b1; delay <= t0_delay; beat <= 0; crit_addr <= MemReadAddress;
      end
    end else if (delay > 1) begin
      delay <= delay - 1;
    end else if (beat <= int'(BW)) begin
      MemDataReady <= 1'b1;
      MemDataIn    <= (beat == 0) ? text(crit_addr)
                                  : text({crit_addr[31:4], 4'b0} + 32'(4 * (beat - 1)));
      beat <= beat + 1;
    end else begin
      MemDataReady <= 1'b0;
      busy         <= 1'b0;
    end
  end

  // Reference model: which memory line each set currently holds.
  bit          mv [SETS];
  int unsigned mline [SETS];
  function automatic bit model_hit(input logic [31:0] a);
    int unsigned line;
    line = a >> 4;
    return mv[line % SETS] && (mline[line % SETS] == line);
  endfunction
  task automatic model_fill(input logic [31:0] a);
    int unsigned line;
    line = a >> 4;
    mv[line % SETS]    = 1'b1;
    mline[line % SETS] = line;
  endtask
  task automatic model_clear();
    for (int i = 0; i < int'(SETS); i++) mv[i] = 1'b0;
  endtask

  // Stimulus helpers (no checking inside).
  task automatic do_reset();
    ReadEnable = 1'b0;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] data, output int lat,
                         output int rcyc, output bit ok, output bit busy_r);
    ReadEnable = 1'b1; ReadAddress = a;
    ok = 1'b0; lat = 0; rcyc = 0; data = '0; busy_r = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (Ready) begin
        data = Instruction; lat = i; rcyc = cyc; busy_r = busy; ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_mem_idle(output int ready_seen, output bit ok);
    ready_seen = 0; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
      if (Ready) ready_seen++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_tests++; if (Ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", Ready); end
    n_tests++; if (Instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", Instruction); end
    n_tests++; if (MemReadRequest !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", MemReadRequest); end
    n_tests++; if (MemReadAddress !== 32'h0) begin n_fail++; $display("FAIL reset_maddr got %h want 0", MemReadAddress); end
    @(posedge clk); #1;
  endtask

  task automatic test_cold_miss();
    logic [31:0] d; int lat, rc, rs, r0; bit ok, ok2, br;
    t0_delay = 40; r0 = req_count;
    do_read(32'h0001_0008, d, lat, rc, ok, br);
    ReadEnable = 1'b0;
    n_tests++; if (!ok || d !== 32'h1002) begin n_fail++; $display("FAIL cold_crit ok=%0b got %h want 1002", ok, d); end
    n_tests++; if (req_count != r0 + 1) begin n_fail++; $display("FAIL cold_reqs got %0d want 1", req_count - r0); end
    n_tests++; if (last_req_addr !== 32'h0001_0008) begin n_fail++; $display("FAIL cold_maddr got %h want 00010008", last_req_addr); end
    n_tests++; if (rc - last_req_cyc != 41) begin n_fail++; $display("FAIL cold_latency got %0d want 41", rc - last_req_cyc); end
    wait_mem_idle(rs, ok2);
    n_tests++; if (!ok2 || rs != 0) begin n_fail++; $display("FAIL cold_fill_ready ok=%0b got %0d want 0", ok2, rs); end
    model_fill(32'h0001_0008);
  endtask

  task automatic test_hits();
    logic [31:0] addrs [3];
    int r0;
    addrs[0] = 32'h0001_0000; addrs[1] = 32'h0001_0004; addrs[2] = 32'h0001_000C;
    r0 = req_count;
    ReadEnable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ReadAddress = addrs[i];
      @(negedge clk);
      n_tests++;
      if (Ready !== 1'b1 || Instruction !== text(addrs[i])) begin
        n_fail++; $display("FAIL hit_%0d ready=%b got %h want %h", i, Ready, Instruction, text(addrs[i]));
      end
      @(posedge clk); #1;
    end
    ReadEnable = 1'b0;
    n_tests++; if (req_count != r0) begin n_fail++; $display("FAIL hit_reqs got %0d want 0", req_count - r0); end
  endtask

  task automatic test_conflict();
    logic [31:0] addrs [3];
    logic [31:0] d; int lat, rc, rs, r0; bit ok, ok2, br, eh;
    addrs[0] = 32'h0001_0000; addrs[1] = 32'h0001_0080; addrs[2] = 32'h0001_0000;
    t0_delay = 5;
    for (int i = 0; i < 3; i++) begin
      eh = model_hit(addrs[i]); r0 = req_count;
      do_read(addrs[i], d, lat, rc, ok, br);
      ReadEnable = 1'b0;
      n_tests++; if (!ok || d !== text(addrs[i])) begin n_fail++; $display("FAIL conflict_data_%0d got %h want %h", i, d, text(addrs[i])); end
      n_tests++; if ((req_count - r0) != (eh ? 0 : 1)) begin n_fail++; $display("FAIL conflict_reqs_%0d got %0d want %0d", i, req_count - r0, eh ? 0 : 1); end
      if (!eh) begin
        wait_mem_idle(rs, ok2);
        model_fill(addrs[i]);
      end
    end
  endtask

  task automatic test_fill_request();
    logic [31:0] d; int lat, rc, r0; bit ok, br;
    do_reset(); t0_delay = 3; r0 = req_count;
    do_read(32'h0001_0000, d, lat, rc, ok, br);
    n_tests++; if (!ok || d !== 32'h1000) begin n_fail++; $display("FAIL fillreq_crit got %h want 1000", d); end
    do_read(32'h0001_0004, d, lat, rc, ok, br);
    ReadEnable = 1'b0;
    n_tests++; if (!ok || d !== 32'h1001) begin n_fail++; $display("FAIL fillreq_data got %h want 1001", d); end
    n_tests++; if (lat != int'(BW) || br) begin n_fail++; $display("FAIL fillreq_stall got lat %0d busy %0b want lat %0d busy 0", lat, br, BW); end
    n_tests++; if (req_count != r0 + 1) begin n_fail++; $display("FAIL fillreq_reqs got %0d want 1", req_count - r0); end
    model_fill(32'h0001_0000);
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] d; int lat, rc, rs, r0, bad; bit ok, ok2, br, seen;
    do_reset(); t0_delay = 3;
    do_read(32'h0001_0000, d, lat, rc, ok, br);
    ReadEnable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (MemDataReady && MemDataIn === 32'h1001) begin seen = 1'b1; break; end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    n_tests++; if (!seen) begin n_fail++; $display("FAIL midfill_beat2 got none want beat 2"); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (Ready !== 1'b0 || MemReadRequest !== 1'b0) bad++;
    end
    @(posedge clk); #1;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL midfill_quiet got %0d active cycles want 0", bad); end
    r0 = req_count;
    do_read(32'h0001_0000, d, lat, rc, ok, br);
    ReadEnable = 1'b0;
    n_tests++; if (req_count != r0 + 1) begin n_fail++; $display("FAIL midfill_rereq got %0d want 1", req_count - r0); end
    n_tests++; if (!ok || d !== 32'h1000) begin n_fail++; $display("FAIL midfill_data got %h want 1000", d); end
    wait_mem_idle(rs, ok2);
    model_fill(32'h0001_0000);
  endtask

  task automatic test_crit_last();
    logic [31:0] d; int lat, rc, rs, r0; bit ok, ok2, br;
    do_reset(); t0_delay = 40; r0 = req_count;
    do_read(32'h0001_000C, d, lat, rc, ok, br);
    ReadEnable = 1'b0;
    n_tests++; if (!ok || d !== 32'h1003) begin n_fail++; $display("FAIL critlast_data got %h want 1003", d); end
    n_tests++; if (rc - last_req_cyc != 41) begin n_fail++; $display("FAIL critlast_latency got %0d want 41", rc - last_req_cyc); end
    wait_mem_idle(rs, ok2);
    n_tests++; if (!ok2 || rs != 0) begin n_fail++; $display("FAIL critlast_fill_ready got %0d want 0", rs); end
    model_fill(32'h0001_000C);
    do_read(32'h0001_0000, d, lat, rc, ok, br);
    ReadEnable = 1'b0;
    n_tests++; if (!ok || d !== 32'h1000 || lat != 0) begin n_fail++; $display("FAIL critlast_hit got %h lat %0d want 1000 lat 0", d, lat); end
    n_tests++; if (req_count != r0 + 1) begin n_fail++; $display("FAIL critlast_reqs got %0d want 1", req_count - r0); end
  endtask

  task automatic test_random();
    logic [31:0] a, d; int lat, rc, rs, r0, t0; bit ok, ok2, br, eh;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      a = 32'h0001_0000 + 32'(4 * $urandom_range(0, 255));
      t0 = int'($urandom_range(1, 6));
      t0_delay = t0;
      eh = model_hit(a); r0 = req_count;
      do_read(a, d, lat, rc, ok, br);
      ReadEnable = 1'b0;
      n_tests++; if (!ok || d !== text(a)) begin n_fail++; $display("FAIL rand_data a=%h got %h want %h", a, d, text(a)); end
      if (eh) begin
        n_tests++; if (lat != 0 || req_count != r0) begin n_fail++; $display("FAIL rand_hit a=%h lat %0d reqs %0d want 0 0", a, lat, req_count - r0); end
      end else begin
        n_tests++;
        if (req_count != r0 + 1 || last_req_addr !== a || rc - last_req_cyc != t0 + 1) begin
          n_fail++; $display("FAIL rand_miss a=%h reqs %0d maddr %h lat %0d want 1 %h %0d", a, req_count - r0, last_req_addr, rc - last_req_cyc, a, t0 + 1);
        end
        wait_mem_idle(rs, ok2);
        n_tests++; if (!ok2 || rs != 0) begin n_fail++; $display("FAIL rand_fill_ready a=%h got %0d want 0", a, rs); end
        model_fill(a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hits();
    test_conflict();
    test_fill_request();
    test_reset_mid_fill();
    test_crit_last();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
